spi_fwm_sram_arb: RTL
=====================

# spi_fwm_sram_arb

Arbiter sharing the single SPI-device firmware-mode SRAM port between the RX FIFO write controller (requester 0, `rxf_*`) and the TX FIFO read controller (requester 1, `txf_*`). Selects one requester per SRAM transaction and holds that selection until the SRAM grants. Returns read responses to the issuing requester through an in-order tag queue. Sits between the two FIFO controllers and the SRAM macro in spi_device.

## Interface
- `SramAw`, 11, SRAM word-address width
- `SramDw`, 32, SRAM data width
- `MaxOutstanding`, 2, max granted reads awaiting `sram_rvalid` (power of two, ≥1)

- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high
- `rxf_req`/`txf_req` in 1: request
- `rxf_write`/`txf_write` in 1: 1 = write, 0 = read
- `rxf_addr`/`txf_addr` in SramAw: word address
- `rxf_wdata`/`txf_wdata` in SramDw: write data
- `rxf_gnt`/`txf_gnt` out 1: request accepted by SRAM
- `rxf_rvalid`/`txf_rvalid` out 1: read data valid
- `rxf_rdata`/`txf_rdata` out SramDw: read data (`sram_rdata`, unmasked)
- `rxf_error`/`txf_error` out 2: `sram_error`, qualified by own rvalid, else 0
- `sram_req` out 1; `sram_write` out 1; `sram_addr` out SramAw; `sram_wdata` out SramDw
- `sram_gnt` in 1; `sram_rvalid` in 1; `sram_rdata` in SramDw; `sram_error` in 2
- `outstanding_o` out $clog2(MaxOutstanding)+1: queued read count
- `rsp_err_o` out 1: sticky; `sram_rvalid` arrived with empty tag queue

## Operation
- FSM `StIdle`, `StLock`. Registers: `st`, `owner` (1b), `rr_last` (1b, last granted), tag queue (MaxOutstanding × 1b, wr/rd ptr, count).
- `stall` = queue full (count == MaxOutstanding). When stalled: `sram_req`=0, no gnt, FSM holds state.
- StIdle, not stalled: winner = arbitration over `{txf_req, rxf_req}`; if any request, `sram_req`=1, SRAM outputs mux winner's write/addr/wdata.
  - `sram_gnt`=1 → winner's gnt=1; `rr_last`←winner; push winner's id if read; stay StIdle.
  - `sram_gnt`=0 → `owner`←winner, go StLock.
- StLock, not stalled: `sram_req` = owner's req, SRAM outputs mux owner only; other requester ignored. On `sram_gnt`: owner gnt, `rr_last`←owner, push if read, go StIdle. Owner drops req → go StIdle, nothing issued.
- Round-robin: both requesting → the one ≠ `rr_last` wins; single requester always wins.
- Writes: no tag, no rvalid expected.
- Response: `sram_rvalid` pops head tag; head 0 → `rxf_rvalid`, 1 → `txf_rvalid`. Push and pop same cycle: count unchanged.
- `sram_rvalid` with empty queue: no requester rvalid, no pop, `rsp_err_o`←1 until reset.
- Non-selected requester's gnt/rvalid/error always 0; `*_gnt` never asserted while `sram_req`=0.
- `sram_gnt` while `sram_req`=0: ignored.

## Timing
- Grant combinational from `sram_gnt` (0-cycle arbiter latency); rvalid/rdata/error combinational passthrough.
- `owner`, `rr_last`, queue, `st` update on posedge `clk_i`.
- Reset: `st`=StIdle, `owner`=0, `rr_last`=1 (rxf wins first tie), queue empty, `outstanding_o`=0, `rsp_err_o`=0; combinational outputs 0 with idle inputs. Reset mid-transaction drops queued tags; late `sram_rvalid` after reset sets `rsp_err_o`.
- Requester must hold req/write/addr/wdata stable until its gnt.

## Configuration
- `SPI_FWM_ARB_PRIO_EN` defined: fixed priority, rxf always wins ties in StIdle (RX overflow avoidance); `rr_last` unused but still reset. StLock hold unchanged.
- Undefined: round-robin as above.

## Test plan
- Reset, rxf read addr 0x010 with `sram_gnt`=1 same cycle, `sram_rvalid` next cycle rdata 0xDEADBEEF → `rxf_gnt` pulse, then `rxf_rvalid`=1 rdata 0xDEADBEEF, `txf_rvalid`=0, `outstanding_o` 1→0.
- Both request (rxf write 0x005, txf read 0x100), gnt always 1 → grants rxf, txf, rxf, txf alternating; with `SPI_FWM_ARB_PRIO_EN` → rxf every cycle.
- txf read 0x020, `sram_gnt` low 3 cycles while rxf asserts → `sram_addr`=0x020 held all 4 cycles, txf granted on 4th, rxf granted next.
- MaxOutstanding=2, two txf reads granted, no rvalid, third request → `sram_req`=0, `outstanding_o`=2; one `sram_rvalid` → `sram_req` resumes.
- Interleaved rxf read, txf read, rvalid ×2 → first rvalid to rxf, second to txf, `sram_error`=2'b01 on second → `txf_error`=01, `rxf_error`=00.
- `sram_rvalid` with empty queue → `rsp_err_o`=1, no requester rvalid; `rst_i` pulse → 0.

Source files
------------

// File: rtl/spi_fwm_sram_arb_if.sv
// rtl/spi_fwm_sram_arb_if.sv - bus bundle between the FIFO controllers, the arbiter and the SRAM port
//
// Groups the rxf (requester 0) and txf (requester 1) request/response
// signals together with the shared SRAM port.
//   slave  : arbiter view (requests and SRAM responses in, grants/responses and SRAM request out)
//   master : environment view (FIFO controllers and SRAM macro)
interface spi_fwm_sram_arb_if #(
    parameter int SramAw = 11,
    parameter int SramDw = 32
);
    logic              rxf_req;
    logic              rxf_write;
    logic [SramAw-1:0] rxf_addr;
    logic [SramDw-1:0] rxf_wdata;
    logic              rxf_gnt;
    logic              rxf_rvalid;
    logic [SramDw-1:0] rxf_rdata;
    logic [1:0]        rxf_error;

    logic              txf_req;
    logic              txf_write;
    logic [SramAw-1:0] txf_addr;
    logic [SramDw-1:0] txf_wdata;
    logic              txf_gnt;
    logic              txf_rvalid;
    logic [SramDw-1:0] txf_rdata;
    logic [1:0]        txf_error;

    logic              sram_req;
    logic              sram_write;
    logic [SramAw-1:0] sram_addr;
    logic [SramDw-1:0] sram_wdata;
    logic              sram_gnt;
    logic              sram_rvalid;
    logic [SramDw-1:0] sram_rdata;
    logic [1:0]        sram_error;

    modport slave (
        input  rxf_req, rxf_write, rxf_addr, rxf_wdata,
        output rxf_gnt, rxf_rvalid, rxf_rdata, rxf_error,
        input  txf_req, txf_write, txf_addr, txf_wdata,
        output txf_gnt, txf_rvalid, txf_rdata, txf_error,
        output sram_req, sram_write, sram_addr, sram_wdata,
        input  sram_gnt, sram_rvalid, sram_rdata, sram_error
    );

    modport master (
        output rxf_req, rxf_write, rxf_addr, rxf_wdata,
        input  rxf_gnt, rxf_rvalid, rxf_rdata, rxf_error,
        output txf_req, txf_write, txf_addr, txf_wdata,
        input  txf_gnt, txf_rvalid, txf_rdata, txf_error,
        input  sram_req, sram_write, sram_addr, sram_wdata,
        output sram_gnt, sram_rvalid, sram_rdata, sram_error
    );
endinterface

// File: rtl/spi_fwm_sram_arb.sv
// rtl/spi_fwm_sram_arb.sv - shares the firmware-mode SRAM port between the RX and TX FIFO controllers
//
// Picks one requester per SRAM transaction, holds the pick until the SRAM
// grants, and routes read responses back through an in-order tag queue.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : rxf_*/txf_* requester ports and sram_* port (slave modport)
//   outstanding_o : number of granted reads still awaiting sram_rvalid
//   rsp_err_o     : sticky, sram_rvalid seen with no read outstanding
// Build option: SPI_FWM_ARB_PRIO_EN selects fixed priority (rxf wins ties)
// instead of round-robin.
module spi_fwm_sram_arb #(
    parameter int SramAw         = 11,
    parameter int SramDw         = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    spi_fwm_sram_arb_if.slave                 bus,
    output logic [$clog2(MaxOutstanding):0]   outstanding_o,
    output logic                              rsp_err_o
);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding) + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

    typedef enum logic {StIdle, StLock} st_e;

    st_e                 st_q, st_d;
    logic                owner_q, owner_d;
    logic                rr_last_q, rr_last_d;
    logic [MaxOutstanding-1:0] tag_q, tag_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                rsp_err_q, rsp_err_d;

    logic                stall;
    logic                win;
    logic                sel;
    logic                sel_req;
    logic                sel_write;
    logic [SramAw-1:0]   sel_addr;
    logic [SramDw-1:0]   sel_wdata;
    logic                req_out;
    logic                granted;
    logic                push;
    logic                pop;
    logic                head;

    // A single-entry queue has no pointer bits to advance.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (MaxOutstanding == 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        st_d      = st_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;

        stall = (cnt_q == CntFull);

`ifdef SPI_FWM_ARB_PRIO_EN
        // rxf first so the RX FIFO never overflows while tx traffic is heavy.
        win = !bus.rxf_req;
`else
        if (bus.rxf_req && bus.txf_req) begin
            win = !rr_last_q;
        end else begin
            win = bus.txf_req;
        end
`endif

        // While locked only the owner is looked at; the other side waits.
        sel       = (st_q == StLock) ? owner_q : win;
        sel_req   = sel ? bus.txf_req   : bus.rxf_req;
        sel_write = sel ? bus.txf_write : bus.rxf_write;
        sel_addr  = sel ? bus.txf_addr  : bus.rxf_addr;
        sel_wdata = sel ? bus.txf_wdata : bus.rxf_wdata;

        req_out = !stall && sel_req;
        granted = req_out && bus.sram_gnt;
        push    = granted && !sel_write;
        pop     = bus.sram_rvalid && (cnt_q != '0);
        head    = tag_q[rd_ptr_q];

        case (st_q)
            StIdle: begin
                if (req_out && !bus.sram_gnt) begin
                    owner_d = win;
                    st_d    = StLock;
                end
            end
            StLock: begin
                if (!stall && (!sel_req || bus.sram_gnt)) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase

        if (granted) begin
            rr_last_d = sel;
        end
        if (push) begin
            tag_d[wr_ptr_q] = sel;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (bus.sram_rvalid && (cnt_q == '0)) begin
            rsp_err_d = 1'b1;
        end
    end

    assign bus.sram_req   = req_out;
    assign bus.sram_write = req_out && sel_write;
    assign bus.sram_addr  = req_out ? sel_addr  : '0;
    assign bus.sram_wdata = req_out ? sel_wdata : '0;

    assign bus.rxf_gnt    = granted && !sel;
    assign bus.txf_gnt    = granted && sel;
    assign bus.rxf_rvalid = pop && !head;
    assign bus.txf_rvalid = pop && head;
    assign bus.rxf_rdata  = bus.sram_rdata;
    assign bus.txf_rdata  = bus.sram_rdata;
    assign bus.rxf_error  = (pop && !head) ? bus.sram_error : 2'b00;
    assign bus.txf_error  = (pop && head)  ? bus.sram_error : 2'b00;

    assign outstanding_o = cnt_q;
    assign rsp_err_o     = rsp_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q      <= StIdle;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
endmodule
